// File: rtl/rv32im_pkg.sv
// Shared RV32M definitions: funct3 codes, M-group select prefix, special-case constants
// and the multi-cycle unit's state encoding.
package rv32im_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    localparam logic [1:0] MD_GROUP = 2'b01;

    localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix
    } md_state_e;

endpackage

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M unit: radix-2 shift-add multiply and restoring divide on unsigned
// magnitudes, with a single sign fix-up before the registered result.
module mul_div_unit
    import rv32im_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [4:0]       SELECT,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic               hold_q, hold_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [2:0]         funct3;
    logic               s1, s2, use1, use2, sign_in, special;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     mul_sum, rem_sh;
    logic [WIDTH-1:0]   rem_diff;
    logic               rem_ge;
    logic [2*WIDTH-1:0] acc_mul, acc_div, fix_src, fix_val;
    logic [WIDTH-1:0]   fix_res;

    // Operand conditioning and per-step datapath.
    always_comb begin
        funct3  = SELECT[2:0];
        s1      = DATA1[WIDTH-1];
        s2      = DATA2[WIDTH-1];
        use1    = funct3 inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        use2    = funct3 inside {OP_MULH, OP_DIV, OP_REM};
        mag1    = (use1 && s1) ? (~DATA1 + WIDTH'(1)) : DATA1;
        mag2    = (use2 && s2) ? (~DATA2 + WIDTH'(1)) : DATA2;
        sign_in = 1'b0;
        case (funct3)
            OP_MULH, OP_DIV:   sign_in = s1 ^ s2;
            OP_MULHSU, OP_REM: sign_in = s1;
            default:           sign_in = 1'b0;
        endcase
        special = funct3[2] && ((DATA2 == '0) ||
                  (!funct3[0] && (DATA1 == INT_MIN) && (DATA2 == '1)));

        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        acc_mul = {mul_sum, acc_q[WIDTH-1:1]};

        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, a_q};
        rem_diff = rem_sh[WIDTH-1:0] - a_q;
        acc_div  = rem_ge ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                          : {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};

        // Divide results are zero-extended so one 64-bit negate serves every op.
        fix_src = op_q[2] ? {{WIDTH{1'b0}},
                             (op_q[1] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0])}
                          : acc_q;
        fix_val = neg_q ? (~fix_src + (2*WIDTH)'(1)) : fix_src;
        fix_res = (op_q[2] || (op_q[1:0] == 2'b00)) ? fix_val[WIDTH-1:0]
                                                    : fix_val[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        hold_d   = hold_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (START && (SELECT[4:3] == MD_GROUP)) begin
                    op_d   = funct3;
                    busy_d = 1'b1;
                    cnt_d  = '1;
                    if (special) begin
                        // Preset {remainder, quotient}; FIX holds one cycle before DONE.
                        acc_d   = (DATA2 == '0) ? {DATA1, DIV0_Q} : {{WIDTH{1'b0}}, INT_MIN};
                        neg_d   = 1'b0;
                        hold_d  = 1'b1;
                        state_d = StFix;
                    end else begin
                        a_d     = funct3[2] ? mag2 : mag1;
                        acc_d   = {{WIDTH{1'b0}}, (funct3[2] ? mag1 : mag2)};
                        neg_d   = sign_in;
                        hold_d  = 1'b0;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d = op_q[2] ? acc_div : acc_mul;
                if (cnt_q == '0) begin
                    state_d = StFix;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StFix: begin
                if (hold_q) begin
                    hold_d = 1'b0;
                end else begin
                    result_d = fix_res;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            hold_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            hold_q   <= hold_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign RESULT = result_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M vectors with hand-computed results,
// plus busy-START, mid-op reset, back-to-back and non-M select scenarios.
module tb_mul_div_unit;

    logic        CLK = 1'b0;
    logic        RESET, START;
    logic [4:0]  SELECT;
    logic [31:0] DATA1, DATA2, RESULT;
    logic        BUSY, DONE;

    typedef struct {
        logic [31:0] res;
        int          done_cyc;
        int          busy;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   busy_run = 0;

    mul_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .SELECT (SELECT),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .RESULT (RESULT),
        .BUSY   (BUSY),
        .DONE   (DONE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endfunction

    // Monitor: every DONE pops one expectation and checks value, timing and BUSY length.
    always @(negedge CLK) begin
        exp_t e;
        if (BUSY) busy_run++;
        else if (!DONE) busy_run = 0;
        if (DONE) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=0x%08h required=no_done", RESULT);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_result"}, RESULT, e.res);
                chk({e.name, "_done_cycle"}, cyc, e.done_cyc);
                chk({e.name, "_busy_cycles"}, busy_run, e.busy);
            end
            busy_run = 0;
        end
    end

    // Called at a negedge; accept edge is the next posedge.
    task automatic issue(input logic [4:0] sel, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] exp, input int lat, input string nm);
        SELECT = sel;
        DATA1  = d1;
        DATA2  = d2;
        START  = 1'b1;
        sb.push_back('{res: exp, done_cyc: cyc + 1 + lat, busy: lat, name: nm});
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 80 && !seen; i++) begin
            if (DONE) seen = 1;
            else @(negedge CLK);
        end
        if (!seen) begin
            chk({nm, "_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic quiet_window(input string nm);
        int nb = 0;
        int nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (BUSY) nb++;
            if (DONE) nd++;
        end
        chk({nm, "_busy_count"}, nb, 0);
        chk({nm, "_done_count"}, nd, 0);
    endtask

    localparam int NV = 15;
    logic [4:0]  v_sel [NV] = '{5'h08, 5'h09, 5'h0B, 5'h0A, 5'h09, 5'h0C, 5'h0E, 5'h0C, 5'h0E,
                               5'h0D, 5'h0F, 5'h0C, 5'h0D, 5'h0E, 5'h0C};
    logic [31:0] v_d1  [NV] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0, 32'd7,
                               32'd100, 32'd100, 32'd7, 32'd5, 32'd5, 32'h8000_0000};
    logic [31:0] v_d2  [NV] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd7, 32'd2, 32'd2, 32'hFFFF_FFFB, 32'hFFFF_FFFE,
                               32'd7, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] v_exp [NV] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd0, 32'd1,
                               32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd5,
                               32'h8000_0000};
    int          v_lat [NV] = '{33, 33, 33, 33, 33, 33, 33, 33, 33, 33, 33, 33, 2, 2, 2};
    string       v_nm  [NV] = '{"mul_7_m3", "mulh_min_min", "mulhu_max", "mulhsu_m1_max",
                               "mulh_m3_7", "div_m7_2", "rem_m7_2", "div_0_m5", "rem_7_m2",
                               "divu_100_7", "remu_100_7", "div_7_m2", "divu_by0",
                               "rem_by0", "div_ovf"};

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET  = 1'b1;
        START  = 1'b0;
        SELECT = '0;
        DATA1  = '0;
        DATA2  = '0;
        repeat (3) @(negedge CLK);
        chk("reset_result", RESULT, 32'd0);
        chk("reset_busy", {31'd0, BUSY}, 32'd0);
        chk("reset_done", {31'd0, DONE}, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < NV; i++) begin
            issue(v_sel[i], v_d1[i], v_d2[i], v_exp[i], v_lat[i], v_nm[i]);
            wait_done(v_nm[i]);
            @(negedge CLK);
        end
        issue(5'h0E, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, "rem_ovf");
        wait_done("rem_ovf");
        @(negedge CLK);

        // START with new operands while busy must not disturb the running multiply.
        issue(5'h08, 32'h0001_2345, 32'h10, 32'h0012_3450, 33, "mul_busy_start");
        repeat (4) @(negedge CLK);
        SELECT = 5'h0D;
        DATA1  = 32'd99;
        DATA2  = 32'd3;
        START  = 1'b1;
        @(negedge CLK);
        START  = 1'b0;
        wait_done("mul_busy_start");
        quiet_window("after_busy_start");

        // Reset mid-operation aborts with no DONE.
        issue(5'h08, 32'd3, 32'd5, 32'd15, 33, "mul_aborted");
        repeat (9) @(negedge CLK);
        RESET = 1'b1;
        sb.delete();
        @(negedge CLK);
        RESET = 1'b0;
        chk("abort_busy", {31'd0, BUSY}, 32'd0);
        chk("abort_done", {31'd0, DONE}, 32'd0);
        chk("abort_result", RESULT, 32'd0);
        quiet_window("after_abort");

        // Second op issued in the DONE cycle of the first.
        issue(5'h0B, 32'hFFFF_FFFF, 32'd2, 32'd1, 33, "b2b_first");
        wait_done("b2b_first");
        issue(5'h0D, 32'd1000, 32'd10, 32'd100, 33, "b2b_second");
        wait_done("b2b_second");
        @(negedge CLK);

        // Non-M select is ignored.
        SELECT = 5'b00000;
        DATA1  = 32'd1;
        DATA2  = 32'd2;
        START  = 1'b1;
        @(negedge CLK);
        START  = 1'b0;
        quiet_window("non_m_select");

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
